// File: rtl/axi_gpio.sv
// Memory-mapped GPIO block: output/direction registers, synchronised inputs, separate read and write handshakes.
// Build with GPIO_IRQ_EN defined to add rising-edge interrupts (IRQ_EN / IRQ_STATUS registers).
module axi_gpio #(
  parameter int GpioWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    gpio_awvalid_i,
  input  logic [AddressWidth-1:0] gpio_awaddr_i,
  output logic                    gpio_awready_o,
  input  logic                    gpio_wvalid_i,
  input  logic [31:0]             gpio_wdata_i,
  input  logic [3:0]              gpio_be_i,
  output logic                    gpio_wready_o,
  output logic                    gpio_bvalid_o,
  input  logic                    gpio_bready_i,
  input  logic                    gpio_arvalid_i,
  input  logic [AddressWidth-1:0] gpio_araddr_i,
  output logic                    gpio_arready_o,
  output logic                    gpio_rvalid_o,
  output logic [31:0]             gpio_rdata_o,
  input  logic                    gpio_rready_i,
  input  logic [GpioWidth-1:0]    gpio_i,
  output logic [GpioWidth-1:0]    gpio_o,
  output logic [GpioWidth-1:0]    gpio_oe_o,
  output logic                    gpio_intr_o
);

  localparam logic [2:0] OFF_DATA_OUT   = 3'd0;
  localparam logic [2:0] OFF_DATA_IN    = 3'd1;
  localparam logic [2:0] OFF_DIR        = 3'd2;
  localparam logic [2:0] OFF_IRQ_EN     = 3'd3;
  localparam logic [2:0] OFF_IRQ_STATUS = 3'd4;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic                 w_accept, r_accept;
  logic [2:0]           w_offset, r_offset;
  logic [31:0]          wmask, rd_value;
  logic [31:0]          irq_en_rd, irq_status_rd;
  logic [GpioWidth-1:0] data_out, dir, sync1, sync2;
  logic                 unused_addr_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign w_offset = gpio_awaddr_i[4:2];
  assign r_offset = gpio_araddr_i[4:2];
  assign wmask    = {{8{gpio_be_i[3]}}, {8{gpio_be_i[2]}}, {8{gpio_be_i[1]}}, {8{gpio_be_i[0]}}};

  // Base/mask decode happens in the interconnect, so the remaining address bits are don't-care.
  assign unused_addr_bits = ^{gpio_awaddr_i, gpio_araddr_i};

  always_comb begin
    w_state_next = w_state;
    w_accept     = 1'b0;
    unique case (w_state)
      W_IDLE: if (gpio_awvalid_i && gpio_wvalid_i && !rst_i) begin
        w_accept     = 1'b1;
        w_state_next = W_RESP;
      end
      W_RESP: if (gpio_bready_i) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state;
    r_accept     = 1'b0;
    unique case (r_state)
      R_IDLE: if (gpio_arvalid_i && !rst_i) begin
        r_accept     = 1'b1;
        r_state_next = R_DATA;
      end
      R_DATA: if (gpio_rready_i) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_value = '0;
    unique case (r_offset)
      OFF_DATA_OUT:   rd_value = 32'(data_out);
      OFF_DATA_IN:    rd_value = 32'(sync2);
      OFF_DIR:        rd_value = 32'(dir);
      OFF_IRQ_EN:     rd_value = irq_en_rd;
      OFF_IRQ_STATUS: rd_value = irq_status_rd;
      default:        rd_value = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state      <= W_IDLE;
      r_state      <= R_IDLE;
      gpio_rdata_o <= '0;
    end else begin
      w_state <= w_state_next;
      r_state <= r_state_next;
      if (r_accept) gpio_rdata_o <= rd_value;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_out <= '0;
      dir      <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      sync1 <= gpio_i;
      sync2 <= sync1;
      if (w_accept && w_offset == OFF_DATA_OUT)
        data_out <= GpioWidth'(merge(32'(data_out), gpio_wdata_i, wmask));
      if (w_accept && w_offset == OFF_DIR)
        dir <= GpioWidth'(merge(32'(dir), gpio_wdata_i, wmask));
    end
  end

`ifdef GPIO_IRQ_EN
  logic [GpioWidth-1:0] irq_en, irq_status, data_in_prev, rise, clear;
  logic                 intr_q;

  assign rise  = sync2 & ~data_in_prev;
  assign clear = (w_accept && w_offset == OFF_IRQ_STATUS) ? GpioWidth'(gpio_wdata_i & wmask) : '0;

  // A new edge in the same cycle as a W1C clear keeps the bit set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en       <= '0;
      irq_status   <= '0;
      data_in_prev <= '0;
      intr_q       <= 1'b0;
    end else begin
      data_in_prev <= sync2;
      irq_status   <= (irq_status & ~clear) | rise;
      intr_q       <= |(irq_status & irq_en);
      if (w_accept && w_offset == OFF_IRQ_EN)
        irq_en <= GpioWidth'(merge(32'(irq_en), gpio_wdata_i, wmask));
    end
  end

  assign irq_en_rd     = 32'(irq_en);
  assign irq_status_rd = 32'(irq_status);
  assign gpio_intr_o   = intr_q;
`else
  assign irq_en_rd     = '0;
  assign irq_status_rd = '0;
  assign gpio_intr_o   = 1'b0;
`endif

  assign gpio_awready_o = w_accept;
  assign gpio_wready_o  = w_accept;
  assign gpio_bvalid_o  = (w_state == W_RESP);
  assign gpio_arready_o = r_accept;
  assign gpio_rvalid_o  = (r_state == R_DATA);
  assign gpio_o         = data_out;
  assign gpio_oe_o      = dir;

endmodule

// File: doc/axi_gpio.md
AXI_GPIO -- requirements
Module: axi_gpio

Interface
REQ-001 SHALL have parameter GpioWidth, default 32, number of GPIO pins (1..32).
REQ-002 SHALL have parameter AddressWidth, default 32, bus address width; DataWidth fixed at 32.
REQ-003 SHALL have port clk_i  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports gpio_awvalid_i in 1, gpio_awaddr_i in AddressWidth, gpio_awready_o out 1: write-address channel.
REQ-006 SHALL have ports gpio_wvalid_i in 1, gpio_wdata_i in 32, gpio_be_i in 4, gpio_wready_o out 1: write-data channel with byte enables.
REQ-007 SHALL have ports gpio_bvalid_o out 1, gpio_bready_i in 1: write-response channel.
REQ-008 SHALL have ports gpio_arvalid_i in 1, gpio_araddr_i in AddressWidth, gpio_arready_o out 1: read-address channel.
REQ-009 SHALL have ports gpio_rvalid_o out 1, gpio_rdata_o out 32, gpio_rready_i in 1: read-data channel.
REQ-010 SHALL have ports gpio_i in GpioWidth (asynchronous pins), gpio_o out GpioWidth, gpio_oe_o out GpioWidth, gpio_intr_o out 1.

Function
REQ-011 SHALL decode offset = addr[4:2]: 0 DATA_OUT (RW), 1 DATA_IN (RO), 2 DIR (RW, 1=output), 3 IRQ_EN (RW), 4 IRQ_STATUS (RW1C); higher addr bits ignored (bus performs base/mask decode).
REQ-012 SHALL drive gpio_o = DATA_OUT and gpio_oe_o = DIR directly from registers.
REQ-013 SHALL synchronise gpio_i through two flops; DATA_IN = second flop; bits >= GpioWidth read 0 in every register.
REQ-014 Write FSM SHALL have states W_IDLE, W_RESP.
REQ-015 In W_IDLE, gpio_awready_o and gpio_wready_o SHALL both be 1 for exactly the cycle where gpio_awvalid_i and gpio_wvalid_i are both 1; with only one valid, neither ready asserts.
REQ-016 On acceptance at edge N, register update SHALL occur at edge N and gpio_bvalid_o SHALL be 1 from cycle N+1 (state W_RESP).
REQ-017 gpio_bvalid_o SHALL hold until sampled with gpio_bready_i=1, then return to W_IDLE; no new write accepted while in W_RESP.
REQ-018 Writes SHALL honour gpio_be_i per byte lane; be=0000 modifies nothing but still responds.
REQ-019 Writes to DATA_IN or offsets 5..7 SHALL be ignored and still respond.
REQ-020 Read FSM SHALL have states R_IDLE, R_DATA, independent of write FSM.
REQ-021 In R_IDLE, gpio_arready_o SHALL equal gpio_arvalid_i; on acceptance at edge N, gpio_rdata_o SHALL be registered from the addressed register value before edge N and gpio_rvalid_o SHALL be 1 from cycle N+1.
REQ-022 gpio_rvalid_o and gpio_rdata_o SHALL hold stable until sampled with gpio_rready_i=1; no new read accepted in R_DATA.
REQ-023 Reads of offsets 5..7 SHALL return 0.
REQ-024 Simultaneous read and write of same register SHALL return the pre-write value.

Reset
REQ-025 While rst_i=1 at an edge: DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, sync flops, gpio_rdata_o = 0; both FSMs to IDLE; all ready/valid outputs and gpio_intr_o = 0.
REQ-026 Reset mid-transaction SHALL abandon it with no response issued; first cycle after release behaves as idle.

Configuration
REQ-027 Macro GPIO_IRQ_EN defined: each DATA_IN bit rising edge (prev sampled 0, now 1) SHALL set IRQ_STATUS bit; gpio_intr_o = |(IRQ_STATUS & IRQ_EN), registered one cycle.
REQ-028 Edge set and W1C clear of the same bit in the same cycle: set SHALL win.
REQ-029 Macro GPIO_IRQ_EN undefined: IRQ_EN and IRQ_STATUS SHALL read 0, writes ignored (still respond), gpio_intr_o tied 0, no edge logic synthesised.

Verification
REQ-030 Reset, write 0xA5A5_00FF to offset 0x0 be=1111, bready=1 -> awready/wready one cycle, bvalid next cycle, gpio_o=0x A5A500FF.
REQ-031 Write 0x1234_5678 be=0010 to DATA_OUT=0 -> DATA_OUT reads 0x0000_5600.
REQ-032 gpio_i=0x0000_0003 held 3 cycles, read offset 0x4 with rready low 5 cycles -> rvalid held, rdata=0x3 stable, released on rready.
REQ-033 awvalid=1, wvalid=0 for 4 cycles then wvalid=1 -> no ready until wvalid, single response.
REQ-034 GPIO_IRQ_EN: IRQ_EN=0x1, gpio_i[0] 0->1 -> gpio_intr_o=1; write 0x1 to 0x10 -> intr=0; clear coincident with new edge -> bit stays 1.
REQ-035 Assert rst_i while bvalid pending -> bvalid=0 next cycle, registers 0, next write completes normally.
